output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Per-output-port scheduler for the 4-port switch; one instance per egress port.
//  Inspects the head-of-line header of every input FIFO and selects the FIFOs whose
//  destination field equals PORT_ID, using round-robin arbitration.
//  Pops the granted FIFO, registers the packet and presents it on a valid/ready egress.
//  Single-beat packets: one FIFO entry is one packet.
// PARAMETERS
//  NUM_PORTS  4             number of input FIFOs / requesters
//  PORT_ID    0             egress port this instance serves (0..NUM_PORTS-1)
//  DATA_W     PACKET_WIDTH  packet width (packet_pkg, 16)
//  HDR_W      DATA_W/2      header width presented by each FIFO (8)
//  DEST_LSB   0             LSB of the destination field within the header
//  DEST_W     2             destination field width, $clog2(NUM_PORTS)
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst          in   1                 synchronous, active-high reset
//  fifo_empty   in   NUM_PORTS         per-input FIFO empty flag
//  fifo_header  in   NUM_PORTS*HDR_W   head header of FIFO i at [i*HDR_W +: HDR_W]
//  fifo_data    in   NUM_PORTS*DATA_W  registered FIFO data_out of FIFO i at [i*DATA_W +: DATA_W]
//  fifo_rd_en   out  NUM_PORTS         one-hot pop strobe to the granted FIFO
//  out_data     out  DATA_W            packet to the egress port
//  out_valid    out  1                 out_data holds a packet
//  out_ready    in   1                 egress accepts out_data this cycle
//  grant_id     out  DEST_W            index of the last granted input
//  busy         out  1                 state != IDLE
//  pkt_count    out  16                packets delivered (handshakes), wraps at 0xFFFF->0
// BEHAVIOUR
//  req[i] = !fifo_empty[i] && fifo_header[i][DEST_LSB +: DEST_W] == PORT_ID.
//  Round robin: search starts at rr_ptr, wraps modulo NUM_PORTS, first set req[i] wins.
//    On each grant, rr_ptr <= winner+1 (mod NUM_PORTS).
//  FSM states:
//    IDLE: if any req -> latch winner in grant_id, update rr_ptr, go READ;
//          otherwise stay in IDLE.
//    READ: fifo_rd_en[grant_id]=1 for exactly this one cycle; go LOAD.
//    LOAD: out_data <= fifo_data[grant_id] (FIFO output valid one cycle after rd_en);
//          out_valid <= 1; go SEND.
//    SEND: out_valid=1, and out_data/grant_id stay stable until out_ready.
//          On out_ready: pkt_count++, out_valid <= 0, then re-arbitrate in the same cycle.
//            Any req -> READ with a new grant.
//            No req  -> IDLE.
//  Latency: req visible in IDLE at cycle t -> rd_en at t+1 -> out_valid at t+3.
//  Back-to-back throughput: 1 packet per 3 cycles.
//  fifo_rd_en is all-zero outside READ and is never multi-hot.
//  Requests are ignored in READ and LOAD.
//    A req that deasserts before a grant is simply not served; there is no drop and no error.
//  out_data is registered inside this block, so a later pop of the same FIFO by another
//    arbiter cannot corrupt a pending packet.
//  Headers with a destination outside 0..NUM_PORTS-1 never match any instance; they are
//    stuck at head of line by design.
//  Reset value of every output:
//    fifo_rd_en=0, out_data=0, out_valid=0, grant_id=0, busy=0, pkt_count=0.
//    rr_ptr=0 (input 0 has highest priority), state=IDLE.
//  Reset mid-operation: all state cleared next edge and any popped-but-undelivered packet
//    is discarded; the FIFOs are reset by the same rst.
// TESTING
//  1 Reset: assert rst 2 cycles -> all outputs 0, busy=0.
//  2 Single request (PORT_ID=1): FIFO2 header dest=1, data 0xA512, out_ready=1.
//    rd_en=4'b0100 for 1 cycle; out_valid at +3 with out_data=0xA512; pkt_count=1.
//  3 Round robin: all 4 FIFOs hold dest=PORT_ID, out_ready=1.
//    Grant order 0,1,2,3,0; no input granted twice before the others; rd_en always one-hot.
//  4 Backpressure: out_ready=0 for 10 cycles in SEND.
//    out_valid and out_data stay stable, no rd_en, pkt_count unchanged.
//    out_ready=1 -> one handshake, then the next grant.
//  5 Filtering: FIFO0 dest=2 and FIFO3 dest=PORT_ID.
//    Only FIFO3 is popped; FIFO0 is never read by this instance.
//  6 Reset in LOAD: rst asserted -> next cycle state IDLE, out_valid=0, pkt_count=0.
//    No spurious rd_en after reset release.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Per-egress-port scheduler: round-robin selects an input FIFO whose head header targets
// PORT_ID, pops it, registers the packet and offers it on a valid/ready egress.
module output_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_ID   = 0,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned HDR_W     = DATA_W / 2,
    parameter int unsigned DEST_LSB  = 0,
    parameter int unsigned DEST_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          fifo_empty,
    input  logic [NUM_PORTS*HDR_W-1:0]    fifo_header,
    input  logic [NUM_PORTS*DATA_W-1:0]   fifo_data,
    output logic [NUM_PORTS-1:0]          fifo_rd_en,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEST_W-1:0]             grant_id,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_e;

    state_e               state_q, state_d;
    logic [DEST_W-1:0]    grant_q, grant_d;
    logic [DEST_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic [15:0]          count_q, count_d;
    logic [NUM_PORTS-1:0] req;
    logic                 req_any;
    logic [DEST_W-1:0]    winner;
    logic [DEST_W-1:0]    rr_next;
    logic [NUM_PORTS-1:0] rd_en;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req[i] = !fifo_empty[i] &&
                     (fifo_header[i*HDR_W + DEST_LSB +: DEST_W] == DEST_W'(PORT_ID));
        end
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned idx;
        req_any = 1'b0;
        winner  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (!req_any && req[idx]) begin
                req_any = 1'b1;
                winner  = DEST_W'(idx);
            end
        end
        rr_next = ((int'(winner) + 1) == NUM_PORTS) ? '0 : winner + DEST_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        count_d  = count_q;
        rd_en    = '0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d  = winner;
                    rr_ptr_d = rr_next;
                    state_d  = READ;
                end
            end
            READ: begin
                rd_en[grant_q] = 1'b1;
                state_d        = LOAD;
            end
            LOAD: begin
                data_d  = fifo_data[int'(grant_q)*DATA_W +: DATA_W];
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    valid_d = 1'b0;
                    if (req_any) begin
                        grant_d  = winner;
                        rr_ptr_d = rr_next;
                        state_d  = READ;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign pkt_count  = count_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter (PORT_ID=1) with a small behavioural model of
// four input FIFOs whose data_out registers one cycle after a pop.
module tb_output_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_header;
    logic [63:0] fifo_data;
    logic [3:0]  fifo_rd_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_h [4][16];
    logic [15:0] mem_d [4][16];
    int          wr_ptr [4];
    int          rd_ptr [4];
    logic [15:0] fifo_q [4];

    output_port_arbiter #(.NUM_PORTS(4), .PORT_ID(1), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_header(fifo_header),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rd_ptr[i] <= 0;
                fifo_q[i] <= '0;
            end else if (fifo_rd_en[i]) begin
                fifo_q[i] <= mem_d[i][rd_ptr[i] % 16];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]          = (rd_ptr[i] == wr_ptr[i]);
            fifo_header[i*8 +: 8]  = mem_h[i][rd_ptr[i] % 16];
            fifo_data[i*16 +: 16]  = fifo_q[i];
        end
    end

    task automatic push(input int p, input logic [7:0] h, input logic [15:0] d);
        mem_h[p][wr_ptr[p] % 16] = h;
        mem_d[p][wr_ptr[p] % 16] = d;
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fifo_rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0000", fifo_rd_en); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        push(2, 8'h01, 16'hA512);
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 4'b0100) begin errors++; $display("FAIL single_rd_en got %b exp 0100", fifo_rd_en); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d exp 2", grant_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (fifo_rd_en !== 4'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_load got rd_en %b valid %b exp 0000 0", fifo_rd_en, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hA512) begin errors++; $display("FAIL single_out got valid %b data %h exp 1 a512", out_valid, out_data); end
        @(negedge clk);
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", pkt_count); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got valid %b busy %b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rd;
        logic [15:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, 8'h01, 16'h1000 + 16'(i*16));
            push(i, 8'h01, 16'h1001 + 16'(i*16));
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            exp_rd = 4'b0001 << (g % 4);
            exp_d  = 16'h1000 + 16'((g % 4) * 16) + 16'(g / 4);
            checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL rr_rd_en g%0d got %b exp %b", g, fifo_rd_en, exp_rd); end
            checks++; if (grant_id !== 2'(g % 4)) begin errors++; $display("FAIL rr_grant g%0d got %0d exp %0d", g, grant_id, g % 4); end
            repeat (2) @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL rr_out g%0d got valid %b data %h exp 1 %h", g, out_valid, out_data, exp_d); end
            @(negedge clk);
        end
        checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL rr_count got %0d exp 5", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(1, 8'h01, 16'hB001);
        push(1, 8'h01, 16'hB002);
        @(negedge clk);
        checks++; if (fifo_rd_en !== 4'b0010) begin errors++; $display("FAIL bp_rd_en got %b exp 0010", fifo_rd_en); end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hB001 || fifo_rd_en !== 4'b0 || pkt_count !== 16'd0) begin
                errors++;
                $display("FAIL bp_hold c%0d got valid %b data %h rd_en %b count %0d exp 1 b001 0000 0", c, out_valid, out_data, fifo_rd_en, pkt_count);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (pkt_count !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake got count %0d valid %b exp 1 0", pkt_count, out_valid); end
        checks++; if (fifo_rd_en !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got %b exp 0010", fifo_rd_en); end
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hB002) begin errors++; $display("FAIL bp_second got valid %b data %h exp 1 b002", out_valid, out_data); end
        @(negedge clk);
        checks++; if (pkt_count !== 16'd2 || busy !== 1'b0) begin errors++; $display("FAIL bp_end got count %0d busy %b exp 2 0", pkt_count, busy); end
    endtask

    task automatic test_filtering();
        do_reset();
        push(0, 8'h06, 16'hC000);
        push(3, 8'hF1, 16'hC003);
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL filt_grant got rd_en %b grant %0d exp 1000 3", fifo_rd_en, grant_id); end
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hC003) begin errors++; $display("FAIL filt_out got valid %b data %h exp 1 c003", out_valid, out_data); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (fifo_rd_en !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL filt_quiet c%0d got rd_en %b busy %b exp 0000 0", c, fifo_rd_en, busy); end
        end
        checks++; if (fifo_empty[0] !== 1'b0 || pkt_count !== 16'd1) begin errors++; $display("FAIL filt_fifo0 got empty %b count %0d exp 0 1", fifo_empty[0], pkt_count); end
    endtask

    task automatic test_reset_in_load();
        do_reset();
        push(2, 8'h01, 16'hD002);
        push(2, 8'h01, 16'hD012);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (pkt_count !== 16'd1 || fifo_rd_en !== 4'b0100) begin errors++; $display("FAIL rl_pre got count %0d rd_en %b exp 1 0100", pkt_count, fifo_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) wr_ptr[i] = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_count !== 16'd0) begin errors++; $display("FAIL rl_state got busy %b valid %b count %0d exp 0 0 0", busy, out_valid, pkt_count); end
        checks++; if (out_data !== 16'h0 || grant_id !== 2'd0 || fifo_rd_en !== 4'b0) begin errors++; $display("FAIL rl_outs got data %h grant %0d rd_en %b exp 0000 0 0000", out_data, grant_id, fifo_rd_en); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (fifo_rd_en !== 4'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rl_after c%0d got rd_en %b valid %b exp 0000 0", c, fifo_rd_en, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_filtering();
        test_reset_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
